// File: rtl/msrv32_imem_resp.sv
// Instruction memory with AHB-like ready handshake, wait states and error reply.
// Optional per-word even parity is enabled by defining MSRV32_IMEM_PARITY_EN.
module msrv32_imem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] iaddr_in,
    input  logic        req_in,
    output logic        ahb_ready_out,
    output logic [31:0] instr_out,
    output logic        err_out,
    input  logic        wr_en_in,
    input  logic [31:0] wr_addr_in,
    input  logic [31:0] wr_data_in,
    input  logic        wr_par_flip_in
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [2:0]  WS3   = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           raddr;
    logic [DEPTH_LOG2-1:0] ridx;
    logic [DEPTH_LOG2-1:0] widx;
    logic [31:0]           rdata;
    logic                  load_rsp;
    logic                  wr_ok;
    logic                  par_err;
    logic                  rd_bad;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    assign ridx  = raddr[DEPTH_LOG2+1:2];
    assign widx  = wr_addr_in[DEPTH_LOG2+1:2];
    assign rdata = mem_q[ridx];
    assign wr_ok = wr_en_in && !addr_bad(wr_addr_in);

`ifdef MSRV32_IMEM_PARITY_EN
    logic par_q [DEPTH];

    // Parity plane written alongside the data word; flip injects a fault.
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            par_q[widx] <= (^wr_data_in) ^ wr_par_flip_in;
        end
    end

    assign par_err = (^rdata) != par_q[ridx];
`else
    logic unused_par_flip;
    assign unused_par_flip = wr_par_flip_in;
    assign par_err         = 1'b0;
`endif

    // Array load port; not reset, and read-first against the response load.
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            mem_q[widx] <= wr_data_in;
        end
    end

    // Next-state, wait counter and address latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        raddr    = addr_q;
        load_rsp = 1'b0;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (req_in) begin
                    addr_d = iaddr_in;
                    raddr  = iaddr_in;
                    if (WS3 == 3'd0) begin
                        state_d  = S_RESP;
                        cnt_d    = 3'd0;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS3;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d  = S_RESP;
                    load_rsp = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Response word; error replies collapse to a single NOP.
    always_comb begin
        rd_bad  = addr_bad(raddr) || par_err;
        instr_d = instr_q;
        err_d   = 1'b0;
        if (load_rsp) begin
            instr_d = rd_bad ? NOP : rdata;
            err_d   = rd_bad;
        end
    end

    // State registers; reset aborts any fetch in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            instr_q <= NOP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign ahb_ready_out = (state_q != S_WAIT);
    assign instr_out     = instr_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_msrv32_imem_resp.sv
// Bench for msrv32_imem_resp: three instances (1, 0 and 3 wait states).
// Expected replies are queued at request time and popped at the response cycle.
module tb_msrv32_imem_resp;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          WS [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [3];
    logic [31:0] iaddr [3];
    logic        rdy   [3];
    logic [31:0] instr [3];
    logic        err   [3];
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_flip;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] smem  [int];
    bit          sflip [int];
    logic [32:0] sbq   [$];

    always #5 clk = ~clk;

    msrv32_imem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
        .clk_in(clk), .rst_in(rst), .iaddr_in(iaddr[0]), .req_in(req[0]),
        .ahb_ready_out(rdy[0]), .instr_out(instr[0]), .err_out(err[0]),
        .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
        .wr_par_flip_in(wr_flip)
    );

    msrv32_imem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clk_in(clk), .rst_in(rst), .iaddr_in(iaddr[1]), .req_in(req[1]),
        .ahb_ready_out(rdy[1]), .instr_out(instr[1]), .err_out(err[1]),
        .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
        .wr_par_flip_in(wr_flip)
    );

    msrv32_imem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clk_in(clk), .rst_in(rst), .iaddr_in(iaddr[2]), .req_in(req[2]),
        .ahb_ready_out(rdy[2]), .instr_out(instr[2]), .err_out(err[2]),
        .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
        .wr_par_flip_in(wr_flip)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit a_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    endfunction

    function automatic logic [32:0] model(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (a_bad(a)) return {1'b1, NOP};
`ifdef MSRV32_IMEM_PARITY_EN
        if (sflip[idx]) return {1'b1, NOP};
`endif
        return {1'b0, smem[idx]};
    endfunction

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic load(input logic [31:0] a, input logic [31:0] d,
                        input bit f);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_flip = f;
        @(negedge clk);
        wr_en = 1'b0;
        if (!a_bad(a)) begin
            smem[int'(a >> 2)]  = d;
            sflip[int'(a >> 2)] = f;
        end
    endtask

    // Issues one fetch on instance k; optionally writes wd to the same word
    // on the edge that enters the response cycle. Returns in that cycle.
    task automatic fetch(input int k, input logic [31:0] a,
                         input bit do_wr, input logic [31:0] wd);
        logic [32:0] e;
        req[k]   = 1'b1;
        iaddr[k] = a;
        sbq.push_back(model(a));
        if (do_wr && WS[k] == 0) begin
            wr_en = 1'b1; wr_addr = a; wr_data = wd; wr_flip = 1'b0;
        end
        @(negedge clk);
        req[k]   = 1'b0;
        iaddr[k] = $urandom;
        for (int i = 0; i < WS[k]; i++) begin
            check($sformatf("rdy_wait_u%0d", k), 32'(rdy[k]), 32'd0);
            if (do_wr && i == WS[k] - 1) begin
                wr_en = 1'b1; wr_addr = a; wr_data = wd; wr_flip = 1'b0;
            end
            @(negedge clk);
        end
        if (do_wr) begin
            wr_en = 1'b0;
            smem[int'(a >> 2)]  = wd;
            sflip[int'(a >> 2)] = 1'b0;
        end
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check($sformatf("rdy_resp_u%0d", k), 32'(rdy[k]), 32'd1);
            check($sformatf("instr_u%0d_%h", k, a), instr[k], e[31:0]);
            check($sformatf("err_u%0d_%h", k, a), 32'(err[k]), 32'(e[32]));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k]   = 1'b0;
            iaddr[k] = 32'd0;
        end
        wr_en   = 1'b0;
        wr_addr = 32'd0;
        wr_data = 32'd0;
        wr_flip = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        // Array loads proceed while in reset; bad addresses must be dropped.
        load(32'h0000_0000, 32'h0010_0093, 1'b0);
        load(32'h0000_0004, 32'h0050_0093, 1'b0);
        load(32'h0000_0008, 32'hAAAA_0000, 1'b0);
        load(32'h0000_000C, 32'h0000_0013, 1'b1);
        load(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        load(32'h0000_1004, 32'hFFFF_FFFF, 1'b0);
        load(32'h0000_0005, 32'hFFFF_FFFF, 1'b0);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_rdy_u%0d", k), 32'(rdy[k]), 32'd1);
            check($sformatf("rst_instr_u%0d", k), instr[k], NOP);
            check($sformatf("rst_err_u%0d", k), 32'(err[k]), 32'd0);
        end

        // First edge after reset release accepts the fetch.
        rst = 1'b0;
        fetch(0, 32'h0000_0004, 1'b0, 32'd0);
        @(negedge clk);
        check("idle_rdy_u0", 32'(rdy[0]), 32'd1);
        check("idle_err_u0", 32'(err[0]), 32'd0);
        check("idle_hold_u0", instr[0], 32'h0050_0093);

        // Zero wait states: back-to-back stream with ready held high.
        fetch(1, 32'h0000_0000, 1'b0, 32'd0);
        fetch(1, 32'h0000_0004, 1'b0, 32'd0);
        fetch(1, 32'h0000_0008, 1'b0, 32'd0);
        @(negedge clk);
        check("idle_rdy_u1", 32'(rdy[1]), 32'd1);

        // Address errors: misaligned, out of range, and both at once.
        fetch(0, 32'h0000_0006, 1'b0, 32'd0);
        @(negedge clk);
        check("err_clr_u0", 32'(err[0]), 32'd0);
        fetch(0, 32'h0000_1000, 1'b0, 32'd0);
        fetch(0, 32'h0000_1002, 1'b0, 32'd0);
        fetch(1, 32'h8000_0004, 1'b0, 32'd0);
        fetch(0, 32'h0000_0010, 1'b0, 32'd0);

        // Read-first collision, then re-fetch sees the new word.
        fetch(0, 32'h0000_0008, 1'b1, 32'h1234_5678);
        fetch(0, 32'h0000_0008, 1'b0, 32'd0);
        fetch(1, 32'h0000_0000, 1'b1, 32'hCAFE_F00D);
        fetch(1, 32'h0000_0000, 1'b0, 32'd0);
        @(negedge clk);

        // Reset during the second wait cycle aborts the fetch.
        req[2]   = 1'b1;
        iaddr[2] = 32'h0000_0010;
        @(negedge clk);
        req[2] = 1'b0;
        check("abort_wait1_u2", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        check("abort_wait2_u2", 32'(rdy[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rdy_u2", 32'(rdy[2]), 32'd1);
        check("abort_instr_u2", instr[2], NOP);
        check("abort_err_u2", 32'(err[2]), 32'd0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        fetch(2, 32'h0000_0004, 1'b0, 32'd0);
        fetch(2, 32'h0000_0006, 1'b0, 32'd0);

        // Word stored with inverted parity.
        fetch(0, 32'h0000_000C, 1'b0, 32'd0);
        @(negedge clk);

        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/msrv32_imem_resp.md
MSRV32_IMEM_RESP -- requirements
Module: msrv32_imem_resp

Interface
REQ-001 The block SHALL have a parameter DEPTH_LOG2, default 10, which sets the number of 32-bit words in the array as 2^DEPTH_LOG2.
REQ-002 The block SHALL have a parameter WAIT_STATES, default 1, legal range 0..7, which sets the number of ready-low cycles per fetch.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port iaddr_in, input, 32 bits: fetch byte address from the PC generator.
REQ-006 The block SHALL have port req_in, input, 1 bit: fetch request, sampled together with iaddr_in.
REQ-007 The block SHALL have port ahb_ready_out, input-side name ahb_ready_in at the PC generator, output, 1 bit: high means the data phase is complete and a new address is accepted.
REQ-008 The block SHALL have port instr_out, output, 32 bits: fetched instruction word.
REQ-009 The block SHALL have port err_out, output, 1 bit: the fetch completing this cycle is in error.
REQ-010 The block SHALL have port wr_en_in, input, 1 bit: array load strobe.
REQ-011 The block SHALL have port wr_addr_in, input, 32 bits: byte address of the word to load.
REQ-012 The block SHALL have port wr_data_in, input, 32 bits: word to load.
REQ-013 The block SHALL have port wr_par_flip_in, input, 1 bit: inverts the stored parity on this load; ignored when parity is compiled out.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-015 Acceptance: in IDLE or RESP with ahb_ready_out=1 and req_in=1, the block SHALL latch iaddr_in and go to WAIT, or to RESP when WAIT_STATES=0.
REQ-016 In WAIT, a down-counter loaded with WAIT_STATES SHALL decrement each cycle; ahb_ready_out=0 throughout; the FSM goes to RESP when the counter reaches 1.
REQ-017 In RESP, ahb_ready_out SHALL be 1 and instr_out/err_out SHALL be valid for exactly that cycle; a fetch can be accepted in the same cycle (back-to-back).
REQ-018 In RESP with req_in=0, the FSM SHALL go to IDLE; in IDLE, ahb_ready_out=1 and instr_out holds its last value with err_out=0.
REQ-019 Latency SHALL be WAIT_STATES+1 cycles from the acceptance edge to the RESP cycle; with WAIT_STATES=0, ahb_ready_out never deasserts.
REQ-020 The read index SHALL be latched address bits [DEPTH_LOG2+1:2].
REQ-021 A latched address with bits [1:0] != 0 SHALL give err_out=1 and instr_out=32'h00000013 (NOP).
REQ-022 A latched address with any bit above DEPTH_LOG2+1 set SHALL give err_out=1 and instr_out=32'h00000013.
REQ-023 When both misaligned and out of range, the block SHALL give a single err_out=1 with NOP.
REQ-024 Writes SHALL occur on any edge with wr_en_in=1, independent of FSM state.
REQ-025 Writes with a misaligned or out-of-range wr_addr_in SHALL be dropped silently.
REQ-026 Read/write collision: a write to the same word at the edge that enters RESP SHALL yield the old data in instr_out (read-first).
REQ-027 If iaddr_in changes while ahb_ready_out=0, the change SHALL be ignored; the latched address is used.

Reset
REQ-028 On rst_in=1, the block SHALL immediately force FSM=IDLE, counter=0, ahb_ready_out=1, instr_out=32'h00000013, err_out=0, latched address=0, aborting any fetch in progress.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 The first edge after rst_in falls SHALL be able to accept a fetch.

Configuration
REQ-031 Macro MSRV32_IMEM_PARITY_EN SHALL, when defined, store an even-parity bit per word, computed from wr_data_in on load and inverted when wr_par_flip_in=1.
REQ-032 With MSRV32_IMEM_PARITY_EN defined, a parity mismatch on read SHALL give err_out=1 and instr_out=32'h00000013 in RESP.
REQ-033 With MSRV32_IMEM_PARITY_EN undefined, the block SHALL have no parity storage, wr_par_flip_in unused, and err_out driven only by address checks.

Verification
REQ-034 WAIT_STATES=1; load 0x00500093 at byte address 0x4; req at 0x4 -> ahb_ready_out low 1 cycle, then instr_out=0x00500093, err_out=0 on cycle 2.
REQ-035 WAIT_STATES=0; req held with addresses 0x0,0x4,0x8 over consecutive cycles -> ahb_ready_out constantly 1, three consecutive RESP words in order.
REQ-036 req at 0x00000006, then at 0x00001000 (DEPTH_LOG2=10) -> each gives err_out=1, instr_out=0x00000013.
REQ-037 WAIT_STATES=3; rst_in pulsed during the second WAIT cycle -> ahb_ready_out=1 and instr_out=0x00000013 immediately; the next fetch completes normally with 4-cycle latency.
REQ-038 Word 0x8 holds 0xAAAA0000; write 0x12345678 to 0x8 on the edge entering RESP -> 0xAAAA0000 returned; a re-fetch returns 0x12345678.
REQ-039 With MSRV32_IMEM_PARITY_EN: load 0x00000013 to 0xC with wr_par_flip_in=1, fetch 0xC -> err_out=1; with the macro undefined, the same fetch gives err_out=0.
